mul_column_loader: RTL



---
 rtl/mul_column_pkg.sv | 21 ++
 rtl/mul_column_sr.sv | 41 ++++
 rtl/mul_column_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mul_column_pkg.sv
// Shared geometry helpers and FSM state type for the multiplier column loader.
package mul_column_pkg;

  typedef enum logic [2:0] {IDLE, FILL, READY, WAIT, DONE} state_e;

  // Height of triangular column c in an n x n partial-product array.
  function automatic int H(input int c, input int n);
    return (c + 1 < 2 * n - 1 - c) ? c + 1 : 2 * n - 1 - c;
  endfunction

  // Packed offset of column c: total height of all lower columns.
  function automatic int OFF(input int c, input int n);
    int sum;
    sum = 0;
    for (int unsigned i = 0; i < unsigned'(c); i++) begin
      sum += H(int'(i), n);
    end
    return sum;
  endfunction

endpackage

// File: rtl/mul_column_sr.sv
// One column shift register: serial shift (bit 0 newest) or parallel load.
module mul_column_sr #(
  parameter int HEIGHT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en_i,
  input  logic              ser_in_i,
  input  logic              load_en_i,
  input  logic [HEIGHT-1:0] load_data_i,
  output logic [HEIGHT-1:0] col_o
);

  logic [HEIGHT-1:0] col_q, col_d, shifted;

  if (HEIGHT == 1) begin : g_h1
    assign shifted = ser_in_i;
  end else begin : g_hn
    assign shifted = {col_q[HEIGHT-2:0], ser_in_i};
  end

  always_comb begin
    col_d = col_q;
    if (load_en_i) begin
      col_d = load_data_i;
    end else if (shift_en_i) begin
      col_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  assign col_o = col_q;

endmodule

// File: rtl/mul_column_loader.sv
// Column bank feeding an N x N partial-product compressor, with fill tracking,
// evaluation launch, programmable latency wait and result capture.
module mul_column_loader
  import mul_column_pkg::*;
#(
  parameter int N        = 20,
  parameter int DST_W    = 2 * N + 1,
  parameter int PIPE_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             shift_en,
  input  logic [2*N-2:0]   ser_in,
  input  logic             load_en,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             start,
  input  logic [DST_W-1:0] dst,
  output logic [N*N-1:0]   cols,
  output logic             primed,
  output logic             busy,
  output logic [DST_W-1:0] result,
  output logic             result_valid
);

  localparam int NCOL = 2 * N - 1;
  localparam int CW   = $clog2(N + 1);
  localparam int LW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [DST_W-1:0] result_q, result_d;
  logic             rv_q, rv_d;
  logic             shift_acc, load_acc;

  assign busy      = (state_q == WAIT) || (state_q == DONE);
  assign shift_acc = !mode && shift_en && !busy;
  assign load_acc  = mode && load_en && !busy;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    localparam int HC = H(c, N);
    localparam int OC = OFF(c, N);
    localparam int LO = (c > N - 1) ? c - N + 1 : 0;
    logic [HC-1:0] ld_data;

    // Bit k pairs a[LO+k] with b[c-LO-k]; k runs up the column's diagonal.
    for (genvar k = 0; k < HC; k++) begin : g_bit
      assign ld_data[k] = a[LO+k] & b[c-LO-k];
    end

    mul_column_sr #(.HEIGHT(HC)) u_col (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en_i (shift_acc),
      .ser_in_i   (ser_in[c]),
      .load_en_i  (load_acc),
      .load_data_i(ld_data),
      .col_o      (cols[OC +: HC])
    );
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    lat_d    = lat_q;
    result_d = result_q;
    rv_d     = 1'b0;

    if (load_acc) begin
      fill_d = CW'(N);
    end else if (shift_acc && (fill_q != CW'(N))) begin
      fill_d = fill_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (load_acc) begin
          state_d = READY;
        end else if (shift_acc) begin
          state_d = (fill_d == CW'(N)) ? READY : FILL;
        end
      end
      FILL: begin
        if (load_acc || (fill_d == CW'(N))) begin
          state_d = READY;
        end
      end
      READY: begin
        if (start) begin
          lat_d   = '0;
          state_d = (PIPE_LAT == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (lat_q == LW'(PIPE_LAT - 1)) begin
          state_d = DONE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      DONE: begin
        result_d = dst;
        rv_d     = 1'b1;
        state_d  = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fill_q   <= '0;
      lat_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      lat_q    <= lat_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign primed       = (fill_q == CW'(N));
  assign result       = result_q;
  assign result_valid = rv_q;

endmodule
